// File: rtl/mem_port_arbiter4.sv
// mem_port_arbiter4
// Round-robin arbiter and access sequencer for one shared 32-bit memory port
// serving four requesters. The winner's index drives the 4:1 datapath mux
// select, the memory enable is held for the whole access, and completion or
// timeout is reported with a one-cycle pulse after the access closes.

module mem_port_arbiter4 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       mem_ready_i,
    output logic [1:0] sel_o,
    output logic [3:0] grant_o,
    output logic       mem_en_o,
    output logic [3:0] done_o,
    output logic       err_o,
    output logic       busy_o
);

    // Last legal ACCESS-cycle count value before a stalled access is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  last_r;
    logic [7:0]  cnt_r;
    logic [1:0]  sel_r;
    logic [3:0]  grant_r;
    logic        mem_en_r;
    logic [3:0]  done_r;
    logic        err_r;
    logic        busy_r;

    logic [2:0]  pick_s;      // {valid, index} of the round-robin winner
    logic        cnt_last_s;  // current ACCESS cycle is the last one allowed

    // Binary index to one-hot requester mask.
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] mask;
        case (idx)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Search last+1, last+2, last+3, last (mod 4); the first set request wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!pick[2] && req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Winner selection and timeout detection from current state.
    always_comb begin
        pick_s     = rr_pick(req_i, last_r);
        cnt_last_s = (cnt_r == CNT_LAST);
    end

    // Access sequencer: arbitration, access timing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            last_r   <= 2'd3;
            cnt_r    <= 8'd0;
            sel_r    <= 2'd0;
            grant_r  <= 4'b0000;
            mem_en_r <= 1'b0;
            done_r   <= 4'b0000;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            // Completion and error are single-cycle pulses.
            done_r <= 4'b0000;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_s[2]) begin
                        state_r  <= ST_ACCESS;
                        sel_r    <= pick_s[1:0];
                        grant_r  <= idx_to_onehot(pick_s[1:0]);
                        mem_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                        cnt_r    <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Requests are ignored here; ready has priority over timeout.
                    if (mem_ready_i) begin
                        state_r  <= ST_RELEASE;
                        done_r   <= idx_to_onehot(sel_r);
                        last_r   <= sel_r;
                        grant_r  <= 4'b0000;
                        mem_en_r <= 1'b0;
                    end else if (cnt_last_s) begin
                        state_r  <= ST_RELEASE;
                        err_r    <= 1'b1;
                        last_r   <= sel_r;
                        grant_r  <= 4'b0000;
                        mem_en_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // One quiet cycle so the serviced requester can drop req.
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= 4'b0000;
                    mem_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    cnt_r    <= 8'd0;
                end
            endcase
        end
    end

    assign sel_o    = sel_r;
    assign grant_o  = grant_r;
    assign mem_en_o = mem_en_r;
    assign done_o   = done_r;
    assign err_o    = err_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed bench for mem_port_arbiter4 (TIMEOUT=4): reset, single access,
// round-robin order, pointer rotation, timeout, ready-on-last-cycle, reset
// during an access.

module tb_mem_port_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic       mem_ready_i;
    logic [1:0] sel_o;
    logic [3:0] grant_o;
    logic       mem_en_o;
    logic [3:0] done_o;
    logic       err_o;
    logic       busy_o;

    int total;
    int bad;

    mem_port_arbiter4 #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .mem_ready_i (mem_ready_i),
        .sel_o       (sel_o),
        .grant_o     (grant_o),
        .mem_en_o    (mem_en_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pack expected outputs: {sel, grant, mem_en, done, err, busy}.
    function automatic logic [12:0] ev(input logic [1:0] sel, input logic [3:0] grant,
                                       input logic en, input logic [3:0] done,
                                       input logic err, input logic busy);
        return {sel, grant, en, done, err, busy};
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {sel_o, grant_o, mem_en_o, done_o, err_o, busy_o};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed sel/grant/en/done/err/busy=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] k;
        logic [3:0] g;
        total = 0;
        bad = 0;
        rst = 1'b1;
        req_i = 4'b0000;
        mem_ready_i = 1'b0;
        cyc();
        cyc();
        chk("reset", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        rst = 1'b0;

        // 1: single access to requester 0, ready on 3rd ACCESS cycle
        req_i = 4'b0001;
        cyc(); chk("t1_acc1", ev(2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;  // dropping req must not cancel the access
        cyc(); chk("t1_acc2", ev(2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t1_acc3", ev(2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1));
        mem_ready_i = 1'b1;
        cyc(); chk("t1_rel", ev(2'd0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1));
        mem_ready_i = 1'b0;
        cyc(); chk("t1_idle", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        cyc(); chk("t1_idle2", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

        // 2: from reset, all requesting, ready immediately -> 0,1,2,3,0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_i = 4'b1111;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            k = 2'(i);
            g = 4'b0001 << k;
            cyc(); chk("t2_grant", ev(k, g, 1'b1, 4'b0000, 1'b0, 1'b1));
            cyc(); chk("t2_done", ev(k, 4'b0000, 1'b0, g, 1'b0, 1'b1));
            req_i = 4'b1111 & ~g;  // drop own bit for one cycle
            cyc(); chk("t2_idle", ev(k, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
            req_i = 4'b1111;
        end

        // 3: service requester 1, then 1010 -> 3 before 1
        req_i = 4'b0010;
        cyc(); chk("t3_g1", ev(2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t3_d1", ev(2'd1, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1));
        req_i = 4'b1010;
        cyc(); chk("t3_i1", ev(2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        cyc(); chk("t3_g3", ev(2'd3, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t3_d3", ev(2'd3, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1));
        cyc(); chk("t3_i3", ev(2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        cyc(); chk("t3_g1b", ev(2'd1, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        cyc(); chk("t3_d1b", ev(2'd1, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1));
        cyc(); chk("t3_i1b", ev(2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

        // 4: timeout on requester 2, then 1111 grants requester 3
        mem_ready_i = 1'b0;
        req_i = 4'b0100;
        cyc(); chk("t4_acc1", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        cyc(); chk("t4_acc2", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t4_acc3", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t4_acc4", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t4_err", ev(2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1));
        req_i = 4'b1111;
        cyc(); chk("t4_idle", ev(2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        cyc(); chk("t4_g3", ev(2'd3, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        mem_ready_i = 1'b1;
        cyc(); chk("t4_d3", ev(2'd3, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1));
        mem_ready_i = 1'b0;
        cyc(); chk("t4_i3", ev(2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

        // 5: ready exactly on the 4th ACCESS cycle -> done, no err
        req_i = 4'b0100;
        cyc(); chk("t5_acc1", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        cyc(); chk("t5_acc2", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t5_acc3", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        cyc(); chk("t5_acc4", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        mem_ready_i = 1'b1;
        cyc(); chk("t5_done", ev(2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1));
        mem_ready_i = 1'b0;
        cyc(); chk("t5_idle", ev(2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

        // 6: reset mid-access of requester 2, then 0101 grants 0 first
        req_i = 4'b0100;
        cyc(); chk("t6_acc1", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        cyc(); chk("t6_acc2", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        rst = 1'b1;
        cyc(); chk("t6_rst", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        rst = 1'b0;
        cyc(); chk("t6_quiet", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        req_i = 4'b0101;
        cyc(); chk("t6_g0", ev(2'd0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1));
        mem_ready_i = 1'b1;
        cyc(); chk("t6_d0", ev(2'd0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1));
        cyc(); chk("t6_i0", ev(2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));
        cyc(); chk("t6_g2", ev(2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1));
        req_i = 4'b0000;
        cyc(); chk("t6_d2", ev(2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1));
        mem_ready_i = 1'b0;
        cyc(); chk("t6_i2", ev(2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
